// File: rtl/pico_rv_pkg.sv
// Shared definitions for the pico_rv core: opcodes, instruction field positions
// and the sequencer state encoding.
package pico_rv_pkg;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpOr   = 4'h5;
  localparam logic [3:0] OpXor  = 4'h6;
  localparam logic [3:0] OpShr  = 4'h7;
  localparam logic [3:0] OpBeqz = 4'h8;
  localparam logic [3:0] OpJmp  = 4'h9;
  localparam logic [3:0] OpIn   = 4'hA;
  localparam logic [3:0] OpOut  = 4'hB;
  localparam logic [3:0] OpIllC = 4'hC;
  localparam logic [3:0] OpIllD = 4'hD;
  localparam logic [3:0] OpIllE = 4'hE;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam int unsigned OpMsb  = 15;
  localparam int unsigned OpLsb  = 12;
  localparam int unsigned RdMsb  = 11;
  localparam int unsigned RdLsb  = 9;
  localparam int unsigned RsMsb  = 8;
  localparam int unsigned RsLsb  = 6;
  localparam int unsigned RtMsb  = 5;
  localparam int unsigned RtLsb  = 3;
  localparam int unsigned ImmMsb = 7;
  localparam int unsigned OffMsb = 5;
  localparam int unsigned TgtMsb = 11;

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StPause,
    StHalt
  } state_e;

  // Opcodes whose result goes through the ALU and updates alu_result.
  function automatic logic is_alu_op(logic [3:0] op);
    return (op >= OpAdd) && (op <= OpShr);
  endfunction

endpackage

// File: rtl/pico_rv_alu.sv
// Combinational ALU for the pico_rv core; yields zero for non-ALU opcodes.
module pico_rv_alu
  import pico_rv_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OpAdd:   result = a + b;
      OpSub:   result = a - b;
      OpAnd:   result = a & b;
      OpOr:    result = a | b;
      OpXor:   result = a ^ b;
      OpShr:   result = a >> 1;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/pico_rv_core_p.sv
// Multi-cycle 16-bit-instruction core with fetch handshake, single-step pause,
// HALT state and illegal-opcode flagging.
module pico_rv_core_p
  import pico_rv_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  input  logic              step_en,
  input  logic              step,
  output logic [PC_W-1:0]   pc,
  output logic              instr_valid,
  output logic              branch_taken,
  output logic [DATA_W-1:0] alu_result,
  output logic              illegal_op,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              imem_req_q, imem_req_d;
  logic              instr_valid_q, instr_valid_d;
  logic              branch_q, branch_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] rf_q [8];
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  logic [3:0]        op;
  logic [2:0]        rd, rs, rt;
  logic [7:0]        imm8;
  logic [5:0]        off6;
  logic [11:0]       tgt;
  logic [DATA_W-1:0] rs_val, rt_val, alu_out;
  logic [15:0]       br_sum;

  assign op   = ir_q[OpMsb:OpLsb];
  assign rd   = ir_q[RdMsb:RdLsb];
  assign rs   = ir_q[RsMsb:RsLsb];
  assign rt   = ir_q[RtMsb:RtLsb];
  assign imm8 = ir_q[ImmMsb:0];
  assign off6 = ir_q[OffMsb:0];
  assign tgt  = ir_q[TgtMsb:0];

  // rf_q[0] is never written, so it always reads back as zero.
  assign rs_val = rf_q[rs];
  assign rt_val = rf_q[rt];

  // Branch target computed wide, then truncated so it wraps modulo 2^PC_W.
  assign br_sum = 16'(pc_q) + 16'd1 + {{10{off6[5]}}, off6};

  pico_rv_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op    (op),
    .a     (rs_val),
    .b     (rt_val),
    .result(alu_out)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    instr_valid_d = 1'b0;
    branch_d      = 1'b0;
    illegal_d     = 1'b0;
    alu_d         = alu_q;
    out_d         = out_q;
    rf_we         = 1'b0;
    rf_wdata      = alu_out;

    unique case (state_q)
      StFetch: begin
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_data;
          state_d = StExec;
        end
      end
      StExec: begin
        instr_valid_d = 1'b1;
        pc_d          = pc_q + PC_W'(1);
        if (is_alu_op(op)) begin
          rf_we = 1'b1;
          alu_d = alu_out;
        end
        case (op)
          OpLdi: begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'(imm8);
          end
          OpBeqz: begin
            if (rs_val == '0) begin
              pc_d     = PC_W'(br_sum);
              branch_d = 1'b1;
            end
          end
          OpJmp: begin
            pc_d     = PC_W'(tgt);
            branch_d = 1'b1;
          end
          OpIn: begin
            rf_we    = 1'b1;
            rf_wdata = in_port;
          end
          OpOut:                  out_d     = rs_val;
          OpIllC, OpIllD, OpIllE: illegal_d = 1'b1;
          default: ;
        endcase
        if (op == OpHalt) begin
          state_d = StHalt;
        end else if (step_en) begin
          state_d = StPause;
        end else begin
          state_d = StFetch;
        end
      end
      StPause: begin
        if (step || !step_en) begin
          state_d = StFetch;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase

    // Registered request: low during reset and in its first cycle after release.
    imem_req_d = (state_d == StFetch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StFetch;
      pc_q          <= '0;
      ir_q          <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      branch_q      <= 1'b0;
      illegal_q     <= 1'b0;
      alu_q         <= '0;
      out_q         <= '0;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      branch_q      <= branch_d;
      illegal_q     <= illegal_d;
      alu_q         <= alu_d;
      out_q         <= out_d;
      if (rf_we && (rd != 3'd0)) begin
        rf_q[rd] <= rf_wdata;
      end
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr_valid  = instr_valid_q;
  assign branch_taken = branch_q;
  assign illegal_op   = illegal_q;
  assign alu_result   = alu_q;
  assign out_port     = out_q;
  assign halted       = (state_q == StHalt);

endmodule

// File: tb/tb_pico_rv_core_p.sv
// Directed scoreboard bench for pico_rv_core_p (DATA_W=8, PC_W=4).
module tb_pico_rv_core_p;
  import pico_rv_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [15:0]   imem_data = '0;
  logic [DW-1:0] in_port = 8'hA5;
  logic [DW-1:0] out_port;
  logic          step_en = 1'b0;
  logic          step = 1'b0;
  logic [PW-1:0] pc;
  logic          instr_valid;
  logic          branch_taken;
  logic [DW-1:0] alu_result;
  logic          illegal_op;
  logic          halted;

  pico_rv_core_p #(
    .DATA_W(DW),
    .PC_W  (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .in_port     (in_port),
    .out_port    (out_port),
    .step_en     (step_en),
    .step        (step),
    .pc          (pc),
    .instr_valid (instr_valid),
    .branch_taken(branch_taken),
    .alu_result  (alu_result),
    .illegal_op  (illegal_op),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic          br;
    logic          ill;
    logic [DW-1:0] outp;
    logic [DW-1:0] alu;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem[16];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_cyc = -1;
  int          exp_gap = 0;
  int          n_ret = 0;
  int          wait_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] rtype(logic [3:0] op, logic [2:0] rd, logic [2:0] rs,
                                        logic [2:0] rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(logic [2:0] rd, logic [7:0] imm);
    return {OpLdi, rd, 1'b0, imm};
  endfunction

  function automatic logic [15:0] beqz(logic [2:0] rs, logic [5:0] off);
    return {OpBeqz, 3'b000, rs, off};
  endfunction

  task automatic push(input logic [PW-1:0] p, input logic br, input logic ill,
                      input logic [DW-1:0] o, input logic [DW-1:0] a);
    exp_t e;
    e.pc   = p;
    e.br   = br;
    e.ill  = ill;
    e.outp = o;
    e.alu  = a;
    exp_q.push_back(e);
  endtask

  task automatic load_prog1();
    mem[0]  = ldi(3'd1, 8'd5);
    mem[1]  = ldi(3'd2, 8'd3);
    mem[2]  = rtype(OpAdd, 3'd3, 3'd1, 3'd2);
    mem[3]  = rtype(OpOut, 3'd0, 3'd3, 3'd0);
    mem[4]  = ldi(3'd5, 8'd1);
    mem[5]  = rtype(OpSub, 3'd4, 3'd0, 3'd5);
    mem[6]  = rtype(OpOut, 3'd0, 3'd4, 3'd0);
    mem[7]  = ldi(3'd0, 8'd7);
    mem[8]  = rtype(OpOut, 3'd0, 3'd0, 3'd0);
    mem[9]  = 16'hD000;
    mem[10] = rtype(OpIn, 3'd6, 3'd0, 3'd0);
    mem[11] = rtype(OpXor, 3'd7, 3'd6, 3'd3);
    mem[12] = rtype(OpShr, 3'd7, 3'd7, 3'd0);
    mem[13] = rtype(OpAnd, 3'd7, 3'd7, 3'd6);
    mem[14] = rtype(OpOut, 3'd0, 3'd7, 3'd0);
    mem[15] = 16'hF000;
  endtask

  // Expected retirements: pc after, branch, illegal, out_port, alu_result.
  task automatic push_prog1();
    push(4'd1,  1'b0, 1'b0, 8'h00, 8'h00);
    push(4'd2,  1'b0, 1'b0, 8'h00, 8'h00);
    push(4'd3,  1'b0, 1'b0, 8'h00, 8'h08);
    push(4'd4,  1'b0, 1'b0, 8'h08, 8'h08);
    push(4'd5,  1'b0, 1'b0, 8'h08, 8'h08);
    push(4'd6,  1'b0, 1'b0, 8'h08, 8'hFF);
    push(4'd7,  1'b0, 1'b0, 8'hFF, 8'hFF);
    push(4'd8,  1'b0, 1'b0, 8'hFF, 8'hFF);
    push(4'd9,  1'b0, 1'b0, 8'h00, 8'hFF);
    push(4'd10, 1'b0, 1'b1, 8'h00, 8'hFF);
    push(4'd11, 1'b0, 1'b0, 8'h00, 8'hFF);
    push(4'd12, 1'b0, 1'b0, 8'h00, 8'hAD);
    push(4'd13, 1'b0, 1'b0, 8'h00, 8'h56);
    push(4'd14, 1'b0, 1'b0, 8'h00, 8'h04);
    push(4'd15, 1'b0, 1'b0, 8'h04, 8'h04);
    push(4'd0,  1'b0, 1'b0, 8'h04, 8'h04);
  endtask

  task automatic load_prog2();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0]  = beqz(3'd0, 6'h3E);
    mem[15] = {OpJmp, 12'd3};
    mem[3]  = ldi(3'd1, 8'd1);
    mem[4]  = beqz(3'd1, 6'd5);
    mem[5]  = 16'hF000;
  endtask

  task automatic push_prog2();
    push(4'd15, 1'b1, 1'b0, 8'h00, 8'h00);
    push(4'd3,  1'b1, 1'b0, 8'h00, 8'h00);
    push(4'd4,  1'b0, 1'b0, 8'h00, 8'h00);
    push(4'd5,  1'b0, 1'b0, 8'h00, 8'h00);
    push(4'd6,  1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_out_port", out_port, 0);
    chk("rst_alu_result", alu_result, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_cyc = -1;
    #1;
    chk("req_low_at_release", imem_req, 0);
    @(posedge clk);
    #1;
    chk("req_after_release", imem_req, 1);
  endtask

  task automatic wait_ret(input int target, input int max);
    int k = 0;
    while (n_ret < target && k < max) begin
      wait_cycles(1);
      k++;
    end
    chk("retire_reached", n_ret, target);
  endtask

  task automatic wait_halt(input int max);
    int k = 0;
    while (!halted && k < max) begin
      wait_cycles(1);
      k++;
    end
    chk("halt_reached", halted, 1);
  endtask

  task automatic check_halted(input logic [PW-1:0] pc_exp);
    int base;
    base = n_ret;
    wait_cycles(4);
    chk("halt_halted", halted, 1);
    chk("halt_req_low", imem_req, 0);
    chk("halt_pc", pc, pc_exp);
    chk("halt_no_retire", n_ret, base);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // Memory responder: acks after wait_n request cycles, checks address stability.
  initial begin
    int            wcnt;
    logic          has_addr;
    logic [PW-1:0] held_addr;
    wcnt     = 0;
    has_addr = 1'b0;
    held_addr = '0;
    forever begin
      @(negedge clk);
      if (rst || !imem_req) begin
        imem_ack = 1'b0;
        wcnt     = 0;
        has_addr = 1'b0;
      end else begin
        if (has_addr) begin
          chk("imem_addr_stable", imem_addr, held_addr);
        end else begin
          held_addr = imem_addr;
          has_addr  = 1'b1;
        end
        if (wcnt >= wait_n) begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr];
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end
    end
  end

  // Retirement monitor: pops the scoreboard on every instr_valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (instr_valid) begin
          n_ret++;
          if (exp_gap != 0 && last_cyc >= 0) chk("retire_gap", cyc - last_cyc, exp_gap);
          last_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("retire_expected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("ret_pc", pc, e.pc);
            chk("ret_branch_taken", branch_taken, e.br);
            chk("ret_illegal_op", illegal_op, e.ill);
            chk("ret_out_port", out_port, e.outp);
            chk("ret_alu_result", alu_result, e.alu);
          end
        end else begin
          chk("pulse_idle", {branch_taken, illegal_op}, 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Zero-wait memory: two cycles per instruction.
    load_prog1();
    wait_n  = 0;
    exp_gap = 2;
    push_prog1();
    do_reset();
    wait_halt(200);
    check_halted(4'd0);

    // Three wait cycles per fetch: five cycles per instruction.
    wait_n  = 3;
    exp_gap = 5;
    push_prog1();
    do_reset();
    wait_halt(400);
    check_halted(4'd0);

    // Reset in the middle of a fetch, then branch wrap-around and jump.
    load_prog2();
    wait_n  = 5;
    exp_gap = 0;
    do_reset();
    #1;
    rst = 1'b1;
    #1;
    chk("midfetch_req_drop", imem_req, 0);
    chk("midfetch_pc", pc, 0);
    push_prog2();
    @(negedge clk);
    @(negedge clk);
    wait_n = 0;
    rst    = 1'b0;
    last_cyc = -1;
    #1;
    chk("post_reset_pc", pc, 0);
    wait_halt(200);
    check_halted(4'd6);

    // Single-step mode.
    load_prog1();
    wait_n  = 0;
    exp_gap = 0;
    step_en = 1'b1;
    push_prog1();
    base = n_ret;
    do_reset();
    wait_ret(base + 1, 50);
    wait_cycles(4);
    chk("pause_parked", n_ret, base + 1);
    chk("pause_req_low", imem_req, 0);
    step = 1'b1;
    wait_cycles(1);
    step = 1'b0;
    wait_cycles(6);
    chk("step_pulse_one", n_ret, base + 2);
    step = 1'b1;
    wait_cycles(3);
    step = 1'b0;
    wait_cycles(6);
    chk("step_held_one", n_ret, base + 3);
    step_en = 1'b0;
    wait_halt(200);
    check_halted(4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
